core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter PC_START, default 8'h00, program counter value loaded on reset and on every start.
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have start  input  1  run request, sampled only in IDLE or HALT.
REQ-005 SHALL have imem_addr  output  8  instruction address (current PC).
REQ-006 SHALL have imem_data  input  16  instruction word, valid one cycle after imem_addr is presented (synchronous ROM).
REQ-007 SHALL have alu_opcode  output  3  datapath ALU operation.
REQ-008 SHALL have ra_addr, rb_addr, write_addr  output  4 each  datapath register-file addresses.
REQ-009 SHALL have write_data  output  8  immediate data to datapath.
REQ-010 SHALL have write_en  output  1  register-file write strobe.
REQ-011 SHALL have alu_wb_sel  output  1  write-back source: 1 = ALU result, 0 = write_data.
REQ-012 SHALL have alu_zero, alu_carry  input  1 each  combinational datapath ALU flags.
REQ-013 SHALL have busy, halted, illegal  output  1 each  status.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT; reset state IDLE.
REQ-015 IDLE: start=1 -> FETCH with pc=PC_START; else remain.
REQ-016 FETCH: drive imem_addr=pc -> DECODE (one cycle).
REQ-017 DECODE: latch imem_data into 16-bit IR -> EXEC (one cycle).
REQ-018 EXEC: one cycle; drive datapath per IR; -> FETCH, or -> HALT for HALT/illegal; fixed 3 cycles per instruction.
REQ-019 Opcode IR[15:12] 0x0-0x7 (ALU): alu_opcode=IR[14:12], write_addr=IR[11:8], ra_addr=IR[7:4], rb_addr=IR[3:0], alu_wb_sel=1, write_en=1; flags Z,C registered from alu_zero/alu_carry at end of EXEC; pc+1.
REQ-020 0x8 (LDI): write_addr=IR[11:8], write_data=IR[7:0], alu_wb_sel=0, write_en=1; flags unchanged; pc+1.
REQ-021 0x9 (BZ) / 0xA (BC) / 0xB (JMP): pc=IR[7:0] if Z=1 / C=1 / always, else pc+1; write_en=0.
REQ-022 0xC (NOP): pc+1, no write.
REQ-023 0xF (HALT): -> HALT, pc unchanged, no write.
REQ-024 0xD, 0xE illegal: no write, illegal=1, -> HALT, pc unchanged.
REQ-025 write_en SHALL be 1 only in EXEC of ALU/LDI instructions, exactly one cycle per instruction.
REQ-026 Outside EXEC, alu_opcode, addresses, write_data, alu_wb_sel SHALL be 0.
REQ-027 pc SHALL be 8 bits and wrap 8'hFF+1 -> 8'h00 without error.
REQ-028 busy=1 in FETCH, DECODE, EXEC; halted=1 only in HALT.
REQ-029 HALT: start=1 -> FETCH, pc=PC_START, illegal and Z/C cleared; else remain.
REQ-030 start SHALL be ignored in FETCH, DECODE, EXEC.
REQ-031 Branch uses Z/C as registered before the branch's EXEC (flags from the most recent ALU instruction).

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, pc=PC_START, IR=0, Z=C=0, illegal=0, write_en=0, busy=0, halted=0, all datapath outputs 0, including mid-instruction (no partial write after deassert).
REQ-033 After rst_n rises, block SHALL stay IDLE until start=1.

Verification
REQ-034 Reset mid-EXEC of LDI: rst_n low during write_en -> write_en=0 same instant, state IDLE, pc=00.
REQ-035 Program {8105 LDI r1,05; 8205 LDI r2,05; 3312 ALU op3 r3=r1,r2; F000}, start pulse -> write_en pulses at cycles 3,6,9 after start with write_addr 1,2,3; halted=1 at cycle 12; pc=03.
REQ-036 ALU op with alu_zero=1 then 9040 BZ 40 -> imem_addr=40 in next FETCH; with alu_zero=0 -> imem_addr=pc+1.
REQ-037 JMP FF then NOP at FF -> next fetch address 00 (wrap), no illegal.
REQ-038 Instruction D123 -> illegal=1, halted=1, write_en never asserted; start -> illegal=0, imem_addr=PC_START.
REQ-039 start held high continuously during run -> no restart, pc sequence unaffected.

Source files
------------

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - three-cycle fetch/decode/execute instruction sequencer
module core_sequencer #(
  parameter logic [7:0] PC_START = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [3:0]  write_addr,
  output logic [7:0]  write_data,
  output logic        write_en,
  output logic        alu_wb_sel,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pc;
  logic [7:0]  pc_nxt;
  logic [7:0]  pc_inc;
  logic [15:0] ir;
  logic [15:0] ir_nxt;
  logic        flag_z;
  logic        flag_z_nxt;
  logic        flag_c;
  logic        flag_c_nxt;
  logic        illegal_q;
  logic        illegal_nxt;
  logic [3:0]  opcode;

  assign opcode = ir[15:12];
  // 8-bit add: FF wraps to 00 with no side effect
  assign pc_inc = pc + 8'd1;

  // State and architectural registers; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= PC_START;
      ir        <= 16'h0000;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      flag_z    <= flag_z_nxt;
      flag_c    <= flag_c_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  // Next-state/register update and datapath control; controls are only non-zero in EXEC
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    flag_z_nxt  = flag_z;
    flag_c_nxt  = flag_c;
    illegal_nxt = illegal_q;
    alu_opcode  = 3'd0;
    ra_addr     = 4'd0;
    rb_addr     = 4'd0;
    write_addr  = 4'd0;
    write_data  = 8'd0;
    write_en    = 1'b0;
    alu_wb_sel  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = PC_START;
        end
      end

      S_FETCH: begin
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        // ROM output now reflects the address presented during FETCH
        ir_nxt    = imem_data;
        state_nxt = S_EXEC;
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            alu_opcode = ir[14:12];
            write_addr = ir[11:8];
            ra_addr    = ir[7:4];
            rb_addr    = ir[3:0];
            alu_wb_sel = 1'b1;
            write_en   = 1'b1;
            flag_z_nxt = alu_zero;
            flag_c_nxt = alu_carry;
            pc_nxt     = pc_inc;
          end
          4'h8: begin
            write_addr = ir[11:8];
            write_data = ir[7:0];
            write_en   = 1'b1;
            pc_nxt     = pc_inc;
          end
          4'h9: pc_nxt = flag_z ? ir[7:0] : pc_inc;
          4'hA: pc_nxt = flag_c ? ir[7:0] : pc_inc;
          4'hB: pc_nxt = ir[7:0];
          4'hC: pc_nxt = pc_inc;
          4'hF: state_nxt = S_HALT;
          default: begin
            illegal_nxt = 1'b1;
            state_nxt   = S_HALT;
          end
        endcase
      end

      S_HALT: begin
        if (start) begin
          state_nxt   = S_FETCH;
          pc_nxt      = PC_START;
          illegal_nxt = 1'b0;
          flag_z_nxt  = 1'b0;
          flag_c_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized model-checked bench for core_sequencer
module tb_core_sequencer;

  localparam logic [7:0] PC0 = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [2:0]  alu_opcode;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [3:0]  write_addr;
  logic [7:0]  write_data;
  logic        write_en;
  logic        alu_wb_sel;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        busy;
  logic        halted;
  logic        illegal;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [15:0] rom [256];

  core_sequencer #(.PC_START(PC0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_opcode (alu_opcode),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .alu_wb_sel (alu_wb_sel),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // synchronous instruction ROM
  always @(posedge clk) imem_data <= rom[imem_addr];

  // instruction-level reference: mode 0 idle / 1 running / 2 halted, phase = cycle within instruction
  int          m_mode = 0;
  int          m_phase = 0;
  logic [7:0]  m_pc = PC0;
  logic        m_z = 1'b0;
  logic        m_c = 1'b0;
  logic        m_ill = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] ins;
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_pc = PC0; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_phase = 0; m_pc = PC0; end
    end else if (m_mode == 2) begin
      if (start) begin
        m_mode = 1; m_phase = 0; m_pc = PC0; m_ill = 1'b0; m_z = 1'b0; m_c = 1'b0;
      end
    end else if (m_phase < 2) begin
      m_phase = m_phase + 1;
    end else begin
      m_phase = 0;
      ins = rom[m_pc];
      if (ins[15] == 1'b0) begin
        m_z = alu_zero; m_c = alu_carry; m_pc = m_pc + 8'd1;
      end else begin
        case (ins[15:12])
          4'h8: m_pc = m_pc + 8'd1;
          4'h9: m_pc = m_z ? ins[7:0] : m_pc + 8'd1;
          4'hA: m_pc = m_c ? ins[7:0] : m_pc + 8'd1;
          4'hB: m_pc = ins[7:0];
          4'hC: m_pc = m_pc + 8'd1;
          4'hF: m_mode = 2;
          default: begin m_ill = 1'b1; m_mode = 2; end
        endcase
      end
    end
  end

  function automatic logic [35:0] pack_out();
    return {imem_addr, alu_opcode, ra_addr, rb_addr, write_addr, write_data,
            write_en, alu_wb_sel, busy, halted, illegal};
  endfunction

  function automatic logic [35:0] model_out();
    logic [15:0] ins;
    logic [2:0]  op3 = 3'd0;
    logic [3:0]  ra = 4'd0, rb = 4'd0, wa = 4'd0;
    logic [7:0]  wd = 8'd0;
    logic        we = 1'b0, sel = 1'b0;
    if (m_mode == 1 && m_phase == 2) begin
      ins = rom[m_pc];
      if (ins[15] == 1'b0) begin
        op3 = ins[14:12]; wa = ins[11:8]; ra = ins[7:4]; rb = ins[3:0]; we = 1'b1; sel = 1'b1;
      end else if (ins[15:12] == 4'h8) begin
        wa = ins[11:8]; wd = ins[7:0]; we = 1'b1;
      end
    end
    return {m_pc, op3, ra, rb, wa, wd, we, sel, (m_mode == 1), (m_mode == 2), m_ill};
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    if (rst_n && chk_en) check("cycle_outputs", pack_out(), model_out());
  end

  task automatic reset_low();
    @(negedge clk); #2 rst_n = 1'b0;
  endtask

  task automatic reset_high();
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 256; a++) rom[a] = w;
  endtask

  // leaves the bench at the falling edge just after the start-sampling edge
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    int r = $urandom_range(0, 99);
    logic [15:0] w = 16'($urandom);
    if (r < 40)      w[15] = 1'b0;
    else if (r < 58) w[15:12] = 4'h8;
    else if (r < 68) w[15:12] = 4'h9;
    else if (r < 76) w[15:12] = 4'hA;
    else if (r < 82) w[15:12] = 4'hB;
    else if (r < 90) w[15:12] = 4'hC;
    else if (r < 95) w[15:12] = 4'hF;
    else             w[15:12] = 4'hD + 4'($urandom_range(0, 1));
    return w;
  endfunction

  initial begin
    fill_rom(16'hF000);
    repeat (2) @(posedge clk);
    #2 check("reset_outputs", pack_out(), 36'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_busy", busy, 1'b0);
    check("idle_no_halt", halted, 1'b0);

    // LDI, LDI, ALU, HALT: writes complete at edges 3/6/9 after the start edge, HALT from edge 12
    reset_low();
    fill_rom(16'hF000);
    rom[0] = 16'h8105; rom[1] = 16'h8205; rom[2] = 16'h3312; rom[3] = 16'hF000;
    reset_high();
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("prog_we", write_en, (k == 2 || k == 5 || k == 8));
      if (k == 2) check("prog_wa1", {write_addr, write_data}, 12'h105);
      if (k == 5) check("prog_wa2", {write_addr, write_data}, 12'h205);
      if (k == 8) check("prog_alu", {alu_opcode, write_addr, ra_addr, rb_addr, alu_wb_sel}, 16'h6625);
      if (k == 11) check("prog_not_yet_halted", halted, 1'b0);
    end
    check("prog_halted", halted, 1'b1);
    check("prog_pc", imem_addr, 8'h03);

    // BZ taken, BZ not taken, BC taken
    for (int v = 0; v < 3; v++) begin
      reset_low();
      fill_rom(16'hF000);
      rom[0] = 16'h0123;
      rom[1] = (v == 2) ? 16'hA080 : 16'h9040;
      reset_high();
      alu_zero  = (v == 0);
      alu_carry = (v == 2);
      pulse_start();
      repeat (5) @(negedge clk);
      check("branch_no_write", write_en, 1'b0);
      @(negedge clk);
      check("branch_target", imem_addr, (v == 0) ? 8'h40 : (v == 1) ? 8'h02 : 8'h80);
    end
    alu_zero = 1'b0; alu_carry = 1'b0;

    // JMP FF then NOP at FF wraps to 00
    reset_low();
    fill_rom(16'hF000);
    rom[0] = 16'hB0FF; rom[255] = 16'hC000;
    reset_high();
    pulse_start();
    repeat (3) @(negedge clk);
    check("jmp_ff", imem_addr, 8'hFF);
    repeat (3) @(negedge clk);
    check("wrap_addr", imem_addr, 8'h00);
    check("wrap_no_illegal", illegal, 1'b0);

    // illegal opcode at address 2
    reset_low();
    fill_rom(16'hF000);
    rom[0] = 16'hC000; rom[1] = 16'hC000; rom[2] = 16'hD123;
    reset_high();
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("illegal_no_write", write_en, 1'b0);
    end
    check("illegal_flag", {illegal, halted, imem_addr}, 10'h302);
    pulse_start();
    check("restart_clears", {illegal, busy, imem_addr}, {1'b0, 1'b1, PC0});

    // reset asserted while LDI is writing
    reset_low();
    fill_rom(16'hF000);
    rom[0] = 16'h8107;
    reset_high();
    pulse_start();
    repeat (2) @(negedge clk);
    check("ldi_we_before_reset", {write_en, write_data}, 9'h107);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_exec", pack_out(), 36'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("stay_idle_after_reset", {busy, halted, write_en}, 3'b000);

    // start held high throughout a run
    reset_low();
    fill_rom(16'hF000);
    rom[0] = 16'h8101; rom[1] = 16'hC000; rom[2] = 16'h8202; rom[3] = 16'hF000;
    reset_high();
    @(negedge clk); start = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 0 || k == 3 || k == 6 || k == 9)
        check("held_fetch_addr", imem_addr, 8'(k / 3));
      if (k == 2) check("held_w1", {write_en, write_addr}, 5'h11);
      if (k == 5) check("held_nop", write_en, 1'b0);
      if (k == 8) check("held_w2", {write_en, write_addr}, 5'h12);
    end
    start = 1'b0;
    @(negedge clk);
    check("held_halted", {halted, imem_addr}, 9'h103);

    // randomized programs, start and flags, checked every cycle against the reference
    for (int it = 0; it < 30; it++) begin
      reset_low();
      for (int a = 0; a < 256; a++) rom[a] = rand_instr();
      reset_high();
      repeat (200) begin
        @(negedge clk);
        start     = (it % 5 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        alu_zero  = 1'($urandom_range(0, 1));
        alu_carry = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
